// File: rtl/alu_stream.sv
// alu_stream: registered, handshaked WIDTH-bit ALU for the multicycle datapath.
//
// Takes A/B/FuncCode under a valid/ready handshake and presents the registered
// result on C. Shifts (SHL/ASR/LSR) take their amount from B[SHW-1:0] and run
// iteratively, one bit per cycle. All other ops, and shifts by zero, have a
// latency of one cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload steady until that edge. A
// consumer can rely on C staying stable while out_valid && !out_ready.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (A, B, FuncCode)
//   A, B                operands; B[SHW-1:0] is the shift amount
//   FuncCode            4-bit operation select
//   out_valid/out_ready result handshake (C)
//   C                   registered result
//   dbg_state           current FSM state (0 IDLE, 1 SHIFT, 2 WAIT)
//   flags               {N,Z,C,V}, only when ALU_FLAGS_EN is defined
//
// Build option: define ALU_FLAGS_EN to add the flags port and its logic.
module alu_stream #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FuncCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [1:0]       dbg_state
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_ASR = 4'h7;
  localparam logic [3:0] OP_LSR = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;

  logic [SHW-1:0]   amt;
  logic             is_shift;
  logic             accept;
  logic             slot_free;
  logic             start_shift;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] step_val;
  logic             load;
  logic [WIDTH-1:0] load_val;

  assign amt         = B[SHW-1:0];
  assign is_shift    = (FuncCode == OP_SHL) || (FuncCode == OP_ASR) || (FuncCode == OP_LSR);
  assign slot_free   = !out_valid || out_ready;
  assign in_ready    = (state_q == S_IDLE) && slot_free;
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift && (amt != '0);
  assign dbg_state   = state_q;

  // Single-cycle result. Shift codes land here only with amt == 0, so they
  // pass A through unchanged.
  always_comb begin
    res = '0;
    case (FuncCode)
      4'h0:    res = A + B;
      4'h1:    res = A + ~B + WIDTH'(1);
      4'h2:    res = A & B;
      4'h3:    res = A | B;
      4'h4:    res = ~A;
      4'h5:    res = ~A + WIDTH'(1);
      4'h6:    res = A;
      4'h7:    res = A;
      4'h8:    res = A;
      4'h9:    res = B;
      4'hA:    res = {A[WIDTH-1:WIDTH-4], B[WIDTH-5:0]};
      4'hB:    res = ~(A | B);
      4'hC:    res = A ^ B;
      4'hD:    res = ~(A ^ B);
      4'hE:    res = A;
      4'hF:    res = ~(A & B);
      default: res = '0;
    endcase
  end

  // One iteration of the captured shift.
  always_comb begin
    step_val = work_q;
    case (op_q)
      OP_SHL:  step_val = {work_q[WIDTH-2:0], 1'b0};
      OP_ASR:  step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_LSR:  step_val = {1'b0, work_q[WIDTH-1:1]};
      default: step_val = work_q;
    endcase
  end

  // Next state and result-load decision. The last shift step loads C on
  // the same edge it finishes when the output slot is free. Otherwise the
  // finished value parks in work_q (WAIT) until the slot frees.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = res;
    case (state_q)
      S_IDLE: begin
        if (start_shift) begin
          state_d = S_SHIFT;
        end else if (accept) begin
          load     = 1'b1;
          load_val = res;
        end
      end
      S_SHIFT: begin
        if (cnt_q == SHW'(1)) begin
          if (slot_free) begin
            load     = 1'b1;
            load_val = step_val;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (slot_free) begin
          load     = 1'b1;
          load_val = work_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      C         <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_shift) begin
        work_q <= A;
        cnt_q  <= amt;
        op_q   <= FuncCode;
      end else if (state_q == S_SHIFT) begin
        work_q <= step_val;
        cnt_q  <= cnt_q - SHW'(1);
      end
      if (load) begin
        C         <= load_val;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic sc_q;      // bit shifted out by the most recent shift step
  logic step_bit;
  logic load_c;
  logic load_v;

  assign step_bit = (op_q == OP_SHL) ? work_q[WIDTH-1] : work_q[0];

  // ADD carries exactly when the wrapped sum is below A. SUB's not-borrow
  // is simply A >= B. Overflow is decided from the operand and result signs.
  always_comb begin
    load_c = 1'b0;
    load_v = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (FuncCode == 4'h0) begin
          load_c = (res < A);
          load_v = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
        end else if (FuncCode == 4'h1) begin
          load_c = (A >= B);
          load_v = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
        end
      end
      S_SHIFT: load_c = step_bit;
      S_WAIT:  load_c = sc_q;
      default: load_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= 4'b0000;
      sc_q  <= 1'b0;
    end else begin
      if (state_q == S_SHIFT) sc_q <= step_bit;
      if (load) flags <= {load_val[WIDTH-1], (load_val == '0), load_c, load_v};
    end
  end
`endif

endmodule
